// File: rtl/m_ptw_mem_responder_pkg.sv
// Shared constants and types for the page-table-walk memory responder.
// Holds the FSM state encodings, the default timeout, the request payload
// struct and the range/alignment check used wherever a request is decoded.
package m_ptw_mem_responder_pkg;

    localparam int unsigned PTW_AW      = 32;
    localparam int unsigned PTW_DW      = 32;
    localparam int unsigned PTW_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        PTW_ST_IDLE = 2'd0,
        PTW_ST_MEM  = 2'd1,
        PTW_ST_RESP = 2'd2
    } ptw_state_e;

    typedef struct packed {
        logic [PTW_AW-1:0] addr;
        logic              we;
        logic [PTW_DW-1:0] wdata;
    } ptw_req_t;

    // Unsigned offset compare never wraps, so a window ending exactly at 2^32 is legal.
    function automatic logic ptw_addr_ok(input logic [PTW_AW-1:0] addr,
                                         input logic [PTW_AW-1:0] base,
                                         input logic [PTW_AW-1:0] size);
        logic [PTW_AW-1:0] off;
        off = addr - base;
        return (off < size) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/m_ptw_req_buf.sv
// One-entry request buffer holding a PTW request that arrived while busy.
// Ports: CLK/RST, push (store push_data), pop (release the entry),
// full (entry valid), data (stored request). Push wins over a same-cycle pop,
// so a pop+push leaves the buffer full with the new request.
module m_ptw_req_buf
    import m_ptw_mem_responder_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     push,
    input  logic     pop,
    input  ptw_req_t push_data,
    output logic     full,
    output ptw_req_t data
);

    logic     valid_q;
    ptw_req_t data_q;

    // Entry storage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (push) begin
            valid_q <= 1'b1;
            data_q  <= push_data;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign full = valid_q;
    assign data = data_q;

endmodule

// File: rtl/m_ptw_mem_responder.sv
// Responder end of the MMU page-table-walk port. Each PTE read or A/D write
// is range/alignment checked, forwarded to a variable-latency memory port and
// answered with a one-cycle w_resp; failures (range, misalign, timeout)
// answer with w_err and rdata 0 so the MMU sees an invalid PTE.
// Ports: CLK, RST (async, active-high); MMU side w_req/w_addr/w_we/w_wdata ->
// w_resp/w_rdata/w_err; memory side w_mem_req/addr/we/wdata <- w_mem_ack/rdata;
// w_overflow is sticky when a request is dropped with both slots busy.
module m_ptw_mem_responder
    import m_ptw_mem_responder_pkg::*;
#(
    parameter logic [PTW_AW-1:0] ADDR_BASE      = 32'h8000_0000,
    parameter logic [PTW_AW-1:0] ADDR_SIZE      = 32'h0800_0000,
    parameter int unsigned       TIMEOUT_CYCLES = PTW_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              w_req,
    input  logic [PTW_AW-1:0] w_addr,
    input  logic              w_we,
    input  logic [PTW_DW-1:0] w_wdata,
    output logic              w_resp,
    output logic [PTW_DW-1:0] w_rdata,
    output logic              w_err,
    output logic              w_mem_req,
    output logic [PTW_AW-1:0] w_mem_addr,
    output logic              w_mem_we,
    output logic [PTW_DW-1:0] w_mem_wdata,
    input  logic              w_mem_ack,
    input  logic [PTW_DW-1:0] w_mem_rdata,
    output logic              w_overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    ptw_state_e        state_q, state_d;
    ptw_req_t          lat_q, lat_d, in_req, buf_data, dec_req;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PTW_DW-1:0] rdata_d;
    logic              resp_d, err_d, mem_req_d, ovf_d;
    logic              dec_valid, buf_full, buf_push, buf_pop;

    assign in_req = '{addr: w_addr, we: w_we, wdata: w_wdata};

    m_ptw_req_buf u_req_buf (
        .CLK       (CLK),
        .RST       (RST),
        .push      (buf_push),
        .pop       (buf_pop),
        .push_data (in_req),
        .full      (buf_full),
        .data      (buf_data)
    );

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= PTW_ST_IDLE;
            lat_q      <= '0;
            timer_q    <= '0;
            w_resp     <= 1'b0;
            w_err      <= 1'b0;
            w_rdata    <= '0;
            w_mem_req  <= 1'b0;
            w_overflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            timer_q    <= timer_d;
            w_resp     <= resp_d;
            w_err      <= err_d;
            w_rdata    <= rdata_d;
            w_mem_req  <= mem_req_d;
            w_overflow <= ovf_d;
        end
    end

    assign w_mem_addr  = lat_q.addr;
    assign w_mem_we    = lat_q.we;
    assign w_mem_wdata = lat_q.wdata;

    // Next state, buffer control and response outcome
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        timer_d   = timer_q;
        resp_d    = 1'b0;
        err_d     = 1'b0;
        rdata_d   = w_rdata;
        ovf_d     = w_overflow;
        buf_push  = 1'b0;
        buf_pop   = 1'b0;
        dec_valid = 1'b0;
        dec_req   = in_req;

        case (state_q)
            PTW_ST_IDLE: begin
                dec_valid = w_req;
            end
            PTW_ST_MEM: begin
                timer_d = timer_q + TW'(1);
                if (w_mem_ack) begin
                    state_d = PTW_ST_RESP;
                    resp_d  = 1'b1;
                    rdata_d = lat_q.we ? '0 : w_mem_rdata;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = PTW_ST_RESP;
                    resp_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
                if (w_req) begin
                    if (buf_full) ovf_d    = 1'b1;
                    else          buf_push = 1'b1;
                end
            end
            PTW_ST_RESP: begin
                state_d = PTW_ST_IDLE;
                if (buf_full) begin
                    // Oldest request first; a newcomer takes the freed slot.
                    buf_pop   = 1'b1;
                    dec_valid = 1'b1;
                    dec_req   = buf_data;
                    buf_push  = w_req;
                end else begin
                    // Empty slot: the newcomer is served straight away.
                    dec_valid = w_req;
                end
            end
            default: begin
                state_d = PTW_ST_IDLE;
            end
        endcase

        if (dec_valid) begin
            lat_d = dec_req;
            if (ptw_addr_ok(dec_req.addr, ADDR_BASE, ADDR_SIZE)) begin
                state_d = PTW_ST_MEM;
                timer_d = '0;
            end else begin
                state_d = PTW_ST_RESP;
                resp_d  = 1'b1;
                err_d   = 1'b1;
                rdata_d = '0;
            end
        end

        mem_req_d = (state_d == PTW_ST_MEM);
    end

endmodule

// File: tb/tb_m_ptw_mem_responder.sv
// Bench for m_ptw_mem_responder: transaction-level timing model plus literal checks.
module tb_m_ptw_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] SIZE  = 32'h0800_0000;
    localparam int          TO    = 1024;
    localparam int          NEVER = 1000000;

    logic        CLK, RST;
    logic        w_req, w_we, w_resp, w_err, w_mem_req, w_mem_we, w_mem_ack, w_overflow;
    logic [31:0] w_addr, w_wdata, w_rdata, w_mem_addr, w_mem_wdata, w_mem_rdata;

    m_ptw_mem_responder dut (
        .CLK(CLK), .RST(RST),
        .w_req(w_req), .w_addr(w_addr), .w_we(w_we), .w_wdata(w_wdata),
        .w_resp(w_resp), .w_rdata(w_rdata), .w_err(w_err),
        .w_mem_req(w_mem_req), .w_mem_addr(w_mem_addr), .w_mem_we(w_mem_we),
        .w_mem_wdata(w_mem_wdata), .w_mem_ack(w_mem_ack), .w_mem_rdata(w_mem_rdata),
        .w_overflow(w_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // One accepted request: its service window and response, in cycle numbers.
    typedef struct {
        int          resp;
        int          mr_s;
        int          mr_e;
        int          ack;
        logic        err;
        logic        we;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ack_data;
    } ent_t;

    ent_t ent[$];
    int   last_resp = -1;
    int   ovf_cyc   = -1;
    int   late_ack  = -1;
    int   n_chk     = 0;
    int   n_pass    = 0;
    bit   chk_en    = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    endtask

    // Requests are served in order; service starts when the request arrives or
    // when the previous response goes out, whichever is later. At most two may
    // be waiting on a response at once; a third is dropped.
    function automatic void add_req(input int c, input logic [31:0] a, input logic we,
                                    input logic [31:0] wd, input int d, input logic [31:0] rd);
        ent_t        e;
        int          busy;
        int          s;
        logic [31:0] off;
        busy = 0;
        foreach (ent[i]) if (ent[i].resp > c) busy++;
        if (busy >= 2) begin
            if (ovf_cyc < 0) ovf_cyc = c + 1;
            return;
        end
        s   = (c > last_resp) ? c : last_resp;
        off = a - BASE;
        e.addr = a; e.we = we; e.wdata = wd; e.ack_data = rd;
        e.ack = -1; e.mr_s = 0; e.mr_e = -1;
        if (!(off < SIZE) || (a[1:0] != 2'b00)) begin
            e.resp = s + 1; e.err = 1'b1; e.rdata = 32'h0;
        end else if (d < TO) begin
            e.mr_s = s + 1; e.ack = s + 1 + d; e.mr_e = e.ack;
            e.resp = e.ack + 1; e.err = 1'b0; e.rdata = we ? 32'h0 : rd;
        end else begin
            e.mr_s = s + 1; e.mr_e = s + TO;
            e.resp = s + TO + 1; e.err = 1'b1; e.rdata = 32'h0;
        end
        last_resp = e.resp;
        ent.push_back(e);
    endfunction

    function automatic void model_reset();
        ent.delete();
        last_resp = -1;
        ovf_cyc   = -1;
    endfunction

    // Downstream memory: ack on the cycle the model schedules.
    always @(posedge CLK) begin
        #1;
        w_mem_ack   = 1'b0;
        w_mem_rdata = 32'h0;
        if (late_ack == cyc) begin
            w_mem_ack   = 1'b1;
            w_mem_rdata = 32'hDEAD_BEEF;
        end
        foreach (ent[i]) begin
            if (ent[i].ack == cyc) begin
                w_mem_ack   = 1'b1;
                w_mem_rdata = ent[i].ack_data;
            end
        end
    end

    logic        m_resp, m_err, m_mreq, m_mwe;
    logic [31:0] m_rdata, m_maddr, m_mwd;
    int          m_best;

    // Per-cycle compare against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            m_resp = 1'b0; m_err = 1'b0; m_rdata = 32'h0; m_best = -1;
            m_mreq = 1'b0; m_mwe = 1'b0; m_maddr = 32'h0; m_mwd = 32'h0;
            foreach (ent[i]) begin
                if (ent[i].resp == cyc) begin
                    m_resp = 1'b1;
                    m_err  = ent[i].err;
                end
                if (ent[i].resp <= cyc && ent[i].resp > m_best) begin
                    m_best  = ent[i].resp;
                    m_rdata = ent[i].rdata;
                end
                if (ent[i].mr_s <= cyc && cyc <= ent[i].mr_e) begin
                    m_mreq  = 1'b1;
                    m_maddr = ent[i].addr;
                    m_mwe   = ent[i].we;
                    m_mwd   = ent[i].wdata;
                end
            end
            check1("m_resp", w_resp, m_resp);
            check1("m_err", w_err, m_err);
            check32("m_rdata", w_rdata, m_rdata);
            check1("m_mem_req", w_mem_req, m_mreq);
            check1("m_overflow", w_overflow, (ovf_cyc >= 0) && (cyc >= ovf_cyc));
            if (m_mreq) begin
                check32("m_mem_addr", w_mem_addr, m_maddr);
                check1("m_mem_we", w_mem_we, m_mwe);
                check32("m_mem_wdata", w_mem_wdata, m_mwd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input int d, input logic [31:0] rd);
        w_req = 1'b1; w_addr = a; w_we = we; w_wdata = wd;
        add_req(cyc, a, we, wd, d, rd);
        tick(1);
        w_req = 1'b0; w_addr = 32'h0; w_we = 1'b0; w_wdata = 32'h0;
    endtask

    int c0;

    initial begin
        RST = 1'b1; w_req = 1'b0; w_addr = 32'h0; w_we = 1'b0; w_wdata = 32'h0;
        w_mem_ack = 1'b0; w_mem_rdata = 32'h0;
        tick(1);
        check1("rst_resp", w_resp, 1'b0);
        check1("rst_err", w_err, 1'b0);
        check32("rst_rdata", w_rdata, 32'h0);
        check1("rst_mem_req", w_mem_req, 1'b0);
        check1("rst_overflow", w_overflow, 1'b0);
        tick(1);
        RST = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // Read, ack three cycles after w_mem_req
        c0 = cyc;
        issue(32'h8000_1000, 1'b0, 32'h0, 3, 32'h2000_0C01);
        wait_until(c0 + 4);
        check1("A_no_early_resp", w_resp, 1'b0);
        wait_until(c0 + 5);
        check1("A_resp", w_resp, 1'b1);
        check32("A_rdata", w_rdata, 32'h2000_0C01);
        check1("A_err", w_err, 1'b0);
        tick(2);

        // Write, ack in the first w_mem_req cycle; ack data must not leak into rdata
        c0 = cyc;
        issue(32'h8000_1004, 1'b1, 32'h2000_0CC7, 0, 32'h1234_5678);
        check1("B_mem_req", w_mem_req, 1'b1);
        check1("B_mem_we", w_mem_we, 1'b1);
        check32("B_mem_wdata", w_mem_wdata, 32'h2000_0CC7);
        wait_until(c0 + 2);
        check1("B_resp", w_resp, 1'b1);
        check32("B_rdata", w_rdata, 32'h0);
        check1("B_err", w_err, 1'b0);
        tick(2);

        // Bad accesses: below base, misaligned, one past the end
        c0 = cyc;
        issue(32'h7FFF_FFFC, 1'b0, 32'h0, 0, 32'h0);
        check1("C1_resp", w_resp, 1'b1);
        check1("C1_err", w_err, 1'b1);
        check1("C1_mem_req", w_mem_req, 1'b0);
        tick(2);
        issue(32'h8000_0002, 1'b0, 32'h0, 0, 32'h0);
        check1("C2_resp", w_resp, 1'b1);
        check1("C2_err", w_err, 1'b1);
        check32("C2_rdata", w_rdata, 32'h0);
        tick(2);
        issue(32'h8800_0000, 1'b0, 32'h0, 0, 32'h0);
        check1("C3_err", w_err, 1'b1);
        tick(2);

        // Buffered bad request, then pop+push on the RESP cycle; last word in range
        c0 = cyc;
        issue(32'h8000_3000, 1'b0, 32'h0, 3, 32'h0000_0AB1);
        issue(32'h0000_1000, 1'b0, 32'h0, 0, 32'h0);
        wait_until(c0 + 5);
        check1("F_first_resp", w_resp, 1'b1);
        issue(32'h87FF_FFFC, 1'b1, 32'h0000_00C3, 0, 32'h5555_5555);
        check1("F_bad_resp", w_resp, 1'b1);
        check1("F_bad_err", w_err, 1'b1);
        wait_until(c0 + 7);
        check1("F_mem_req", w_mem_req, 1'b1);
        check32("F_mem_addr", w_mem_addr, 32'h87FF_FFFC);
        wait_until(c0 + 8);
        check1("F_resp", w_resp, 1'b1);
        check1("F_err", w_err, 1'b0);
        check1("F_no_overflow", w_overflow, 1'b0);
        tick(2);

        // Timeout, then a late ack that must be ignored
        c0 = cyc;
        issue(32'h8000_2000, 1'b0, 32'h0, NEVER, 32'h0);
        late_ack = c0 + 1030;
        wait_until(c0 + 1024);
        check1("D_mem_req_last", w_mem_req, 1'b1);
        wait_until(c0 + 1025);
        check1("D_mem_req_drop", w_mem_req, 1'b0);
        check1("D_resp", w_resp, 1'b1);
        check1("D_err", w_err, 1'b1);
        wait_until(c0 + 1031);
        check1("D_late_ack_ignored", w_resp, 1'b0);
        tick(2);

        // Three back-to-back requests: second buffered, third dropped
        c0 = cyc;
        issue(32'h8000_4000, 1'b0, 32'h0, 6, 32'h0000_1111);
        issue(32'h8000_4004, 1'b0, 32'h0, 2, 32'h0000_2222);
        issue(32'h8000_4008, 1'b0, 32'h0, 0, 32'h0000_3333);
        check1("E_overflow", w_overflow, 1'b1);
        wait_until(c0 + 8);
        check1("E_resp1", w_resp, 1'b1);
        check32("E_rdata1", w_rdata, 32'h0000_1111);
        wait_until(c0 + 9);
        check1("E_mem_req2", w_mem_req, 1'b1);
        check32("E_mem_addr2", w_mem_addr, 32'h8000_4004);
        wait_until(c0 + 12);
        check1("E_resp2", w_resp, 1'b1);
        check32("E_rdata2", w_rdata, 32'h0000_2222);
        tick(5);
        check1("E_overflow_sticky", w_overflow, 1'b1);

        // Reset in the middle of a memory access
        c0 = cyc;
        issue(32'h8000_5000, 1'b0, 32'h0, NEVER, 32'h0);
        wait_until(c0 + 3);
        check1("G_mem_req_before", w_mem_req, 1'b1);
        chk_en = 1'b0;
        RST = 1'b1;
        #1;
        check1("G_mem_req_async", w_mem_req, 1'b0);
        check1("G_overflow_clr", w_overflow, 1'b0);
        model_reset();
        tick(2);
        RST = 1'b0;
        chk_en = 1'b1;
        tick(5);
        c0 = cyc;
        issue(32'h8000_0001, 1'b0, 32'h0, 0, 32'h0);
        check1("G_idle_resp", w_resp, 1'b1);
        check1("G_idle_err", w_err, 1'b1);
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
